// File: rtl/fir_interpolator.sv
// Polyphase FIR interpolator: one input sample in, L filtered output samples out,
// computed on a single time-multiplexed multiply-accumulate.
module fir_interpolator #(
  parameter int IW             = 16,
  parameter int CW             = 16,
  parameter int L              = 4,
  parameter int TAPS_PER_PHASE = 5,
  parameter int COEF_FRAC      = 15
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [L*TAPS_PER_PHASE-1:0][CW-1:0]    coefficients,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [IW-1:0]                          data_in,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [IW-1:0]                          data_out
);

  localparam int T    = TAPS_PER_PHASE;
  localparam int NT   = L * T;
  localparam int AW   = IW + CW + $clog2(T);
  localparam int KW   = (T > 1) ? $clog2(T) : 1;
  localparam int PW   = (L > 1) ? $clog2(L) : 1;
  localparam int IDXW = (NT > 1) ? $clog2(NT) : 1;

  localparam logic signed [AW-1:0] HALF    = {{(AW-COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}};
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-IW+1){1'b0}}, {(IW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-IW+1){1'b1}}, {(IW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, ROUND, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic [KW-1:0]           k_q, k_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic signed [IW-1:0]    x_q [T];
  logic signed [IW-1:0]    x_d [T];
  logic [IW-1:0]           data_out_q, data_out_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;

  logic [IDXW-1:0]         coef_idx;
  logic signed [IW+CW-1:0] prod;
  logic signed [AW-1:0]    rounded;
  logic signed [AW-1:0]    shifted;

  // Phase p of the polyphase bank uses taps p, p+L, p+2L, ...
  assign coef_idx = IDXW'(k_q) * IDXW'(L) + IDXW'(phase_q);
  assign prod     = x_q[k_q] * $signed(coefficients[coef_idx]);
  assign rounded  = acc_q + HALF;
  assign shifted  = rounded >>> COEF_FRAC;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    k_d        = k_q;
    acc_d      = acc_q;
    data_out_d = data_out_q;
    for (int i = 0; i < T; i++) x_d[i] = x_q[i];

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          x_d[0] = $signed(data_in);
          for (int i = 1; i < T; i++) x_d[i] = x_q[i-1];
          phase_d = '0;
          k_d     = '0;
          acc_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + AW'(prod);
        k_d   = k_q + KW'(1);
        if (k_q == KW'(T-1)) state_d = ROUND;
      end
      ROUND: begin
        if (shifted > SAT_MAX)      data_out_d = SAT_MAX[IW-1:0];
        else if (shifted < SAT_MIN) data_out_d = SAT_MIN[IW-1:0];
        else                        data_out_d = shifted[IW-1:0];
        state_d = HOLD;
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          if (phase_q != PW'(L-1)) begin
            phase_d = phase_q + PW'(1);
            k_d     = '0;
            acc_d   = '0;
            state_d = MAC;
          end else begin
            phase_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake flags are registered copies of the next state.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      data_out_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < T; i++) x_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      data_out_q  <= data_out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < T; i++) x_q[i] <= x_d[i];
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_fir_interpolator.sv
// Directed bench for fir_interpolator: vector table for impulse/DC/saturation,
// plus hand sequences for latency, back-pressure and mid-operation reset.
module tb_fir_interpolator;

  localparam int IW = 16;
  localparam int CW = 16;
  localparam int L  = 4;
  localparam int T  = 5;
  localparam int NT = L * T;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [NT-1:0][CW-1:0]    coefficients;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [IW-1:0]            data_in = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic [IW-1:0]            data_out;

  int checks = 0;
  int failures = 0;

  fir_interpolator #(
    .IW(IW), .CW(CW), .L(L), .TAPS_PER_PHASE(T), .COEF_FRAC(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .coefficients(coefficients),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data_in(data_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst;
    int csel;
    int din;
    int e0;
    int e1;
    int e2;
    int e3;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic set_coefs(input int csel);
    for (int i = 0; i < NT; i++) begin
      case (csel)
        0:       coefficients[i] = 16'(1000 * (i + 1));
        1:       coefficients[i] = 16'd6554;
        default: coefficients[i] = 16'd32767;
      endcase
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check({name, "_rst_out_valid"}, 32'(out_valid), 0);
    check({name, "_rst_data_out"}, $signed(data_out), 0);
    check({name, "_rst_in_ready"}, 32'(in_ready), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check({name, "_rel_in_ready_low"}, 32'(in_ready), 0);
    @(negedge clk);
    check({name, "_rel_in_ready_high"}, 32'(in_ready), 1);
  endtask

  // Starts and ends just after a falling edge.
  task automatic send(input int din, input string name);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check({name, "_in_ready_timeout"}, 32'(in_ready), 1);
    end else begin
      data_in  = 16'(din);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic collect(input int exp, input string name);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      check({name, "_out_valid_timeout"}, 32'(out_valid), 1);
    end else begin
      check(name, $signed(data_out), exp);
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input int idx, input bit allow_rst);
    vec_t v;
    v = vecs[idx];
    if (allow_rst && v.rst) begin
      set_coefs(v.csel);
      do_reset($sformatf("vec%0d", idx));
    end
    send(v.din, $sformatf("vec%0d", idx));
    collect(v.e0, $sformatf("vec%0d_ph0", idx));
    collect(v.e1, $sformatf("vec%0d_ph1", idx));
    collect(v.e2, $sformatf("vec%0d_ph2", idx));
    collect(v.e3, $sformatf("vec%0d_ph3", idx));
    $display("vec %0d din=%0d expected=%0d,%0d,%0d,%0d", idx, v.din, v.e0, v.e1, v.e2, v.e3);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Impulse of 0.5 through ramp taps: output k is c[k]/2.
    vecs[0]  = '{1'b1, 0, 16384, 500, 1000, 1500, 2000};
    vecs[1]  = '{1'b0, 0, 0, 2500, 3000, 3500, 4000};
    vecs[2]  = '{1'b0, 0, 0, 4500, 5000, 5500, 6000};
    vecs[3]  = '{1'b0, 0, 0, 6500, 7000, 7500, 8000};
    vecs[4]  = '{1'b0, 0, 0, 8500, 9000, 9500, 10000};
    vecs[5]  = '{1'b0, 0, 0, 0, 0, 0, 0};
    // DC: n*6554*10000/32768 rounded as history fills.
    vecs[6]  = '{1'b1, 1, 10000, 2000, 2000, 2000, 2000};
    vecs[7]  = '{1'b0, 1, 10000, 4000, 4000, 4000, 4000};
    vecs[8]  = '{1'b0, 1, 10000, 6000, 6000, 6000, 6000};
    vecs[9]  = '{1'b0, 1, 10000, 8000, 8000, 8000, 8000};
    vecs[10] = '{1'b0, 1, 10000, 10001, 10001, 10001, 10001};
    vecs[11] = '{1'b0, 1, 10000, 10001, 10001, 10001, 10001};
    // Saturation at both rails.
    vecs[12] = '{1'b1, 2, 32767, 32766, 32766, 32766, 32766};
    vecs[13] = '{1'b0, 2, 32767, 32767, 32767, 32767, 32767};
    vecs[14] = '{1'b0, 2, 32767, 32767, 32767, 32767, 32767};
    vecs[15] = '{1'b1, 2, -32768, -32767, -32767, -32767, -32767};
    vecs[16] = '{1'b0, 2, -32768, -32768, -32768, -32768, -32768};
    vecs[17] = '{1'b0, 2, -32768, -32768, -32768, -32768, -32768};

    set_coefs(0);
    #1;
    check("por_out_valid", 32'(out_valid), 0);
    check("por_data_out", $signed(data_out), 0);
    check("por_in_ready", 32'(in_ready), 0);

    for (int i = 0; i < 18; i++) run_vec(i, 1'b1);

    // Latency: accept edge A, then out_valid pulses at A+6, +13, +20, +27.
    set_coefs(0);
    do_reset("lat");
    data_in  = 16'd16384;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 1; n <= 29; n++) begin
      @(negedge clk);
      check($sformatf("lat_out_valid_a%0d", n), 32'(out_valid),
            (n == 6 || n == 13 || n == 20 || n == 27) ? 1 : 0);
      check($sformatf("lat_in_ready_a%0d", n), 32'(in_ready), (n >= 28) ? 1 : 0);
    end
    $display("latency sequence done");

    // Back-pressure in phase 1 with ignored in_valid pulses.
    set_coefs(0);
    do_reset("bp");
    send(16384, "bp");
    collect(500, "bp_ph0");
    out_ready = 1'b0;
    begin
      int n = 0;
      while (!out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp_hold_valid_c%0d", c), 32'(out_valid), 1);
      check($sformatf("bp_hold_data_c%0d", c), $signed(data_out), 1000);
      check($sformatf("bp_hold_in_ready_c%0d", c), 32'(in_ready), 0);
      in_valid = c[0];
      data_in  = 16'd12345;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp_final_valid", 32'(out_valid), 1);
    check("bp_final_data", $signed(data_out), 1000);
    out_ready = 1'b1;
    @(negedge clk);
    collect(1500, "bp_ph2");
    collect(2000, "bp_ph3");
    run_vec(1, 1'b0);
    run_vec(2, 1'b0);
    $display("back-pressure sequence done");

    // Reset while phase 2 is accumulating; the impulse run must then repeat exactly.
    set_coefs(0);
    do_reset("mr");
    send(16384, "mr");
    collect(500, "mr_ph0");
    collect(1000, "mr_ph1");
    @(posedge clk);
    #2;
    check("mr_pre_data_out", $signed(data_out), 1000);
    reset = 1'b1;
    #1;
    check("mr_out_valid", 32'(out_valid), 0);
    check("mr_data_out", $signed(data_out), 0);
    check("mr_in_ready", 32'(in_ready), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mr_rel_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 6; i++) run_vec(i, 1'b0);
    $display("mid-operation reset sequence done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
